// File: rtl/busqueda_pkg.sv
// busqueda_pkg: shared state encodings and default widths for the window search engine
package busqueda_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int CH_W_DEF = 8;
  localparam int ID_W_DEF = 2;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD = 4'd1;
  localparam logic [3:0] S_CMP = 4'd2;
  localparam logic [3:0] S_MARK_BOTH = 4'd3;
  localparam logic [3:0] S_MARK_REF = 4'd4;
  localparam logic [3:0] S_VEC_WR = 4'd5;
  localparam logic [3:0] S_NEXT_REF = 4'd6;
  localparam logic [3:0] S_NEXT_ACT = 4'd7;
  localparam logic [3:0] S_DRAIN_RD = 4'd8;
  localparam logic [3:0] S_DRAIN_CHK = 4'd9;
  localparam logic [3:0] S_DRAIN_WR = 4'd10;
  localparam logic [3:0] S_FINISH = 4'd11;
endpackage

// File: rtl/busqueda_param_pix_match.sv
// pix_match: per-channel absolute difference against a tolerance, all three channels must pass
module pix_match #(
  parameter int CH_W = 8
) (
  input  logic [3*CH_W-1:0] a,
  input  logic [3*CH_W-1:0] b,
  input  logic [CH_W-1:0]   tol,
  output logic              match
);
  logic [2:0] ok;
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [CH_W:0] x, y, d;
    assign x = {1'b0, a[g*CH_W +: CH_W]};
    assign y = {1'b0, b[g*CH_W +: CH_W]};
    assign d = x >= y ? x - y : y - x;
    assign ok[g] = d <= {1'b0, tol};
  end
  assign match = &ok;
endmodule

// File: rtl/busqueda_param.sv
// busqueda_param: pairs ref pixels with matching act pixels, emits motion vectors, then drains ref pixels
module busqueda_param
  import busqueda_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CH_W = CH_W_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic                  clk_fsm,
  input  logic                  rst,
  input  logic                  start,
  output logic                  finish,
  output logic                  idle,
  input  logic [ID_W-1:0]       cont_img,
  input  logic [ADDR_W-1:0]     window_limit,
  input  logic [CH_W-1:0]       match_tol,
  input  logic                  stream_all,
  input  logic                  vector_wait_fifo,
  input  logic                  img_wait_fifo,
  output logic [ID_W+2*ADDR_W-1:0] vector_me,
  output logic                  vector_wr_req,
  output logic [ID_W+3*CH_W-1:0] img_mb,
  output logic                  img_wr_req,
  input  logic [3*CH_W:0]       data_rd_img_ref,
  input  logic [3*CH_W:0]       data_rd_img_act,
  output logic [ADDR_W-1:0]     add_img_ref,
  output logic [ADDR_W-1:0]     add_img_act,
  output logic [3*CH_W:0]       data_wr_img_ref,
  output logic [3*CH_W:0]       data_wr_img_act,
  output logic                  wr_enable_ref,
  output logic                  wr_enable_act,
  output logic [ADDR_W-1:0]     vec_count,
  output logic [ADDR_W-1:0]     pix_count,
  output logic [3:0]            real_state
);
  localparam int PW = 3 * CH_W;
  logic [3:0] state, state_nx;
  logic [ADDR_W-1:0] ref_idx, act_idx, vec_cnt, pix_cnt;
  logic [PW-1:0] ref_pix, act_pix;
  logic [ADDR_W:0] ref_inc, act_inc, lim;
  logic pix_eq, same, hit, ref_last, act_more, drain_take, vec_fire, img_fire;
  pix_match #(.CH_W(CH_W)) u_match (
    .a(data_rd_img_ref[PW-1:0]),
    .b(data_rd_img_act[PW-1:0]),
    .tol(match_tol),
    .match(pix_eq)
  );
  assign lim = {1'b0, window_limit};
  assign ref_inc = {1'b0, ref_idx} + (ADDR_W+1)'(1);
  assign act_inc = {1'b0, act_idx} + (ADDR_W+1)'(1);
  assign ref_last = ref_inc >= lim;
  assign act_more = act_inc < lim;
  assign same = ref_idx == act_idx;
  assign hit = pix_eq && !(data_rd_img_act[PW] && !same);
  assign drain_take = stream_all || !data_rd_img_ref[PW];
  assign vec_fire = state == S_VEC_WR && !vector_wait_fifo;
  assign img_fire = state == S_DRAIN_WR && !img_wait_fifo;
  assign idle = state == S_IDLE;
  assign finish = state == S_FINISH;
  assign vector_wr_req = vec_fire;
  assign img_wr_req = img_fire;
  assign wr_enable_ref = state == S_MARK_BOTH || state == S_MARK_REF;
  assign wr_enable_act = state == S_MARK_BOTH;
  assign vector_me = {cont_img, ref_idx, act_idx};
  assign img_mb = {cont_img, ref_pix};
  assign data_wr_img_ref = {1'b1, ref_pix};
  assign data_wr_img_act = {1'b1, act_pix};
  assign add_img_ref = ref_idx;
  assign add_img_act = act_idx;
  assign vec_count = vec_cnt;
  assign pix_count = pix_cnt;
  assign real_state = state;
  // next-state selection; FIFO-full inputs hold the write states in place
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:      state_nx = start ? (window_limit == '0 ? S_FINISH : S_RD) : S_IDLE;
      S_RD:        state_nx = S_CMP;
      S_CMP:       state_nx = hit ? (same ? S_MARK_BOTH : S_VEC_WR) : (act_more ? S_NEXT_ACT : S_MARK_REF);
      S_MARK_BOTH: state_nx = S_NEXT_REF;
      S_MARK_REF:  state_nx = S_NEXT_REF;
      S_VEC_WR:    state_nx = vector_wait_fifo ? S_VEC_WR : S_MARK_BOTH;
      S_NEXT_REF:  state_nx = ref_last ? S_DRAIN_RD : S_RD;
      S_NEXT_ACT:  state_nx = S_RD;
      S_DRAIN_RD:  state_nx = S_DRAIN_CHK;
      S_DRAIN_CHK: state_nx = drain_take ? S_DRAIN_WR : (ref_last ? S_FINISH : S_DRAIN_RD);
      S_DRAIN_WR:  state_nx = img_wait_fifo ? S_DRAIN_WR : (ref_last ? S_FINISH : S_DRAIN_RD);
      default:     state_nx = S_IDLE;
    endcase
  end
  // state, window indices, pixel latches and search counters
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      state <= S_IDLE;
      ref_idx <= '0;
      act_idx <= '0;
      vec_cnt <= '0;
      pix_cnt <= '0;
      ref_pix <= '0;
      act_pix <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        ref_idx <= '0;
        act_idx <= '0;
        vec_cnt <= '0;
        pix_cnt <= '0;
      end
      if (state == S_CMP) begin
        ref_pix <= data_rd_img_ref[PW-1:0];
        act_pix <= data_rd_img_act[PW-1:0];
      end
      if (state == S_DRAIN_CHK) ref_pix <= data_rd_img_ref[PW-1:0];
      if (state == S_NEXT_REF) begin
        ref_idx <= ref_last ? '0 : ref_inc[ADDR_W-1:0];
        act_idx <= ref_inc[ADDR_W-1:0];
      end
      if (state == S_NEXT_ACT) act_idx <= act_inc[ADDR_W-1:0];
      if ((state == S_DRAIN_CHK && !drain_take) || img_fire) ref_idx <= ref_inc[ADDR_W-1:0];
      if (vec_fire) vec_cnt <= vec_cnt + ADDR_W'(1);
      if (img_fire) pix_cnt <= pix_cnt + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_busqueda_param.sv
// tb_busqueda_param: directed searches over a small RAM model, checked by a queue-driven monitor
module tb_busqueda_param;
  localparam int AW = 14;
  localparam int CW = 8;
  localparam int IW = 2;
  localparam int PW = 3 * CW;
  localparam int C_CLR = 0, C_IDLE = 1, C_FIN = 2, C_ST = 3, C_VC = 4, C_PC = 5, C_VR = 6, C_IR = 7, C_WE = 8;
  localparam int C_NFIN = 9, C_NVEC = 10, C_NIMG = 11, C_NWE = 12, C_NWAIT = 13, C_QV = 14, C_QI = 15, C_QF = 16;
  localparam logic [PW-1:0] PX = 24'h102030, PY = 24'h405060, PZ = 24'h708090, PQ = 24'h0a0b0c, PR = 24'hc0d0e0;
  typedef struct {int code; logic [63:0] exp; string name;} probe_t;
  typedef struct packed {logic [AW-1:0] vc; logic [AW-1:0] pc; logic [15:0] ur; logic [15:0] ua;} fin_t;
  logic clk = 0, rst = 1, start = 0, stream_all = 0, vector_wait_fifo = 0, img_wait_fifo = 0, ld = 0;
  logic [IW-1:0] cont_img = '0;
  logic [AW-1:0] window_limit = '0;
  logic [CW-1:0] match_tol = '0;
  logic finish, idle, vector_wr_req, img_wr_req, wr_enable_ref, wr_enable_act;
  logic [IW+2*AW-1:0] vector_me;
  logic [IW+PW-1:0] img_mb;
  logic [PW:0] data_rd_img_ref, data_rd_img_act, data_wr_img_ref, data_wr_img_act;
  logic [AW-1:0] add_img_ref, add_img_act, vec_count, pix_count;
  logic [3:0] real_state;
  logic [PW:0] mem_ref [16], mem_act [16], init_ref [16], init_act [16];
  probe_t pq [$];
  logic [IW+2*AW-1:0] exp_vec [$];
  logic [IW+PW-1:0] exp_img [$];
  fin_t exp_fin [$];
  int checks = 0, errors = 0;
  int n_fin = 0, n_vec = 0, n_img = 0, n_we = 0, n_wait = 0;
  always #5 clk = ~clk;
  busqueda_param #(.ADDR_W(AW), .CH_W(CW), .ID_W(IW)) dut (
    .clk_fsm(clk), .rst(rst), .start(start), .finish(finish), .idle(idle),
    .cont_img(cont_img), .window_limit(window_limit), .match_tol(match_tol), .stream_all(stream_all),
    .vector_wait_fifo(vector_wait_fifo), .img_wait_fifo(img_wait_fifo),
    .vector_me(vector_me), .vector_wr_req(vector_wr_req), .img_mb(img_mb), .img_wr_req(img_wr_req),
    .data_rd_img_ref(data_rd_img_ref), .data_rd_img_act(data_rd_img_act),
    .add_img_ref(add_img_ref), .add_img_act(add_img_act),
    .data_wr_img_ref(data_wr_img_ref), .data_wr_img_act(data_wr_img_act),
    .wr_enable_ref(wr_enable_ref), .wr_enable_act(wr_enable_act),
    .vec_count(vec_count), .pix_count(pix_count), .real_state(real_state)
  );
  // one-cycle-latency RAM pair with a bulk preload port
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) begin
        mem_ref[i] <= init_ref[i];
        mem_act[i] <= init_act[i];
      end
    end else begin
      if (wr_enable_ref) mem_ref[add_img_ref[3:0]] <= data_wr_img_ref;
      if (wr_enable_act) mem_act[add_img_act[3:0]] <= data_wr_img_act;
    end
    data_rd_img_ref <= mem_ref[add_img_ref[3:0]];
    data_rd_img_act <= mem_act[add_img_act[3:0]];
  end
  task automatic cmp(input string n, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, g, e);
    end
  endtask
  function automatic logic [63:0] probe(input int c);
    case (c)
      C_IDLE:  return 64'(idle);
      C_FIN:   return 64'(finish);
      C_ST:    return 64'(real_state);
      C_VC:    return 64'(vec_count);
      C_PC:    return 64'(pix_count);
      C_VR:    return 64'(vector_wr_req);
      C_IR:    return 64'(img_wr_req);
      C_WE:    return 64'({wr_enable_ref, wr_enable_act});
      C_NFIN:  return 64'(n_fin);
      C_NVEC:  return 64'(n_vec);
      C_NIMG:  return 64'(n_img);
      C_NWE:   return 64'(n_we);
      C_NWAIT: return 64'(n_wait);
      C_QV:    return 64'(exp_vec.size());
      C_QI:    return 64'(exp_img.size());
      C_QF:    return 64'(exp_fin.size());
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction
  // monitor: evaluates queued probes, then matches every DUT output event against the scoreboard
  always @(negedge clk) begin : mon
    probe_t p;
    fin_t f;
    logic [15:0] ur, ua;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      if (p.code == C_CLR) begin
        n_fin = 0; n_vec = 0; n_img = 0; n_we = 0; n_wait = 0;
      end else cmp(p.name, probe(p.code), p.exp);
    end
    if (vector_wr_req) begin
      if (exp_vec.size() == 0) cmp("vector_extra", 64'(vector_wr_req), 0);
      else cmp("vector_me", 64'(vector_me), 64'(exp_vec.pop_front()));
    end
    if (img_wr_req) begin
      if (exp_img.size() == 0) cmp("img_extra", 64'(img_wr_req), 0);
      else cmp("img_mb", 64'(img_mb), 64'(exp_img.pop_front()));
    end
    if (finish) begin
      if (exp_fin.size() == 0) cmp("finish_extra", 64'(finish), 0);
      else begin
        f = exp_fin.pop_front();
        for (int i = 0; i < 16; i++) begin
          ur[i] = mem_ref[i][PW];
          ua[i] = mem_act[i][PW];
        end
        cmp("vec_count", 64'(vec_count), 64'(f.vc));
        cmp("pix_count", 64'(pix_count), 64'(f.pc));
        cmp("ref_used", 64'(ur), 64'(f.ur));
        cmp("act_used", 64'(ua), 64'(f.ua));
      end
    end
    n_fin += int'(finish);
    n_vec += int'(vector_wr_req);
    n_img += int'(img_wr_req);
    n_we += int'(wr_enable_ref | wr_enable_act);
    n_wait += int'(real_state == 4'd5 && vector_wait_fifo);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic p(input int c, input logic [63:0] e, input string n);
    pq.push_back('{code: c, exp: e, name: n});
  endtask
  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      init_ref[i] = {1'b0, 24'h5a5a00 | 24'(i)};
      init_act[i] = {1'b0, 24'ha5a500 | 24'(i)};
    end
  endtask
  task automatic load();
    ld = 1;
    tick(1);
    ld = 0;
  endtask
  task automatic load_xyz();
    fill();
    init_ref[0] = {1'b0, PX}; init_ref[1] = {1'b0, PY}; init_ref[2] = {1'b0, PZ};
    init_act[0] = {1'b0, PQ}; init_act[1] = {1'b0, PX}; init_act[2] = {1'b0, PR};
    load();
  endtask
  task automatic load_tol();
    fill();
    init_ref[0] = {1'b0, 24'h101010}; init_ref[1] = {1'b0, 24'h800000};
    init_act[0] = {1'b0, 24'h00ff00}; init_act[1] = {1'b0, 24'h121010};
    load();
  endtask
  task automatic go(input int lim, input int tol, input logic sa);
    window_limit = AW'(lim);
    match_tol = CW'(tol);
    stream_all = sa;
    start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic wait_state(input logic [3:0] s, input string n);
    int k;
    k = 0;
    while (real_state != s && k < 1000) begin
      tick(1);
      k++;
    end
    if (real_state != s) begin
      $display("FAIL %s: state %0d never reached, last state %0d", n, s, real_state);
      $fatal(1, "timeout");
    end
  endtask
  task automatic wait_fin(input string n);
    wait_state(4'd11, n);
    tick(1);
  endtask
  initial begin
    tick(3);
    p(C_IDLE, 1, "rst_idle"); p(C_FIN, 0, "rst_finish"); p(C_ST, 0, "rst_state");
    p(C_VC, 0, "rst_vec_count"); p(C_PC, 0, "rst_pix_count");
    p(C_VR, 0, "rst_vec_req"); p(C_IR, 0, "rst_img_req"); p(C_WE, 0, "rst_wr_en");
    rst = 0;
    tick(1);
    // identical frames: every entry marks itself in both RAMs
    fill();
    init_ref[0] = {1'b0, 24'h112233}; init_ref[1] = {1'b0, 24'h445566};
    init_ref[2] = {1'b0, 24'h778899}; init_ref[3] = {1'b0, 24'haabbcc};
    for (int i = 0; i < 4; i++) init_act[i] = init_ref[i];
    load();
    cont_img = 2'd1;
    p(C_CLR, 0, "");
    exp_fin.push_back('{vc: 0, pc: 0, ur: 16'h000f, ua: 16'h000f});
    go(4, 0, 0);
    wait_fin("same_frames");
    p(C_NFIN, 1, "same_finish_pulses"); p(C_NVEC, 0, "same_vectors");
    p(C_NIMG, 0, "same_pixels"); p(C_NWE, 4, "same_mark_cycles");
    // one displaced match, drain everything
    load_xyz();
    cont_img = 2'd2;
    p(C_CLR, 0, "");
    exp_vec.push_back({2'd2, 14'd0, 14'd1});
    exp_img.push_back({2'd2, PX}); exp_img.push_back({2'd2, PY}); exp_img.push_back({2'd2, PZ});
    exp_fin.push_back('{vc: 1, pc: 3, ur: 16'h0007, ua: 16'h0002});
    go(3, 0, 1);
    wait_fin("xyz_all");
    p(C_NFIN, 1, "xyz_finish_pulses"); p(C_NVEC, 1, "xyz_vectors");
    p(C_NIMG, 3, "xyz_pixels"); p(C_NWE, 3, "xyz_mark_cycles");
    // same data with the vector FIFO full for five cycles, unmarked-only drain
    load_xyz();
    cont_img = 2'd3;
    p(C_CLR, 0, "");
    exp_vec.push_back({2'd3, 14'd0, 14'd1});
    exp_fin.push_back('{vc: 1, pc: 0, ur: 16'h0007, ua: 16'h0002});
    vector_wait_fifo = 1;
    go(3, 0, 0);
    wait_state(4'd5, "vec_wait_enter");
    tick(2);
    p(C_ST, 5, "vec_wait_hold_state"); p(C_VR, 0, "vec_wait_no_req");
    tick(3);
    vector_wait_fifo = 0;
    wait_fin("vec_wait");
    p(C_NVEC, 1, "vec_wait_pulses"); p(C_NWAIT, 5, "vec_wait_cycles"); p(C_NIMG, 0, "vec_wait_pixels");
    // tolerance just below and at the channel difference
    load_tol();
    cont_img = 2'd0;
    p(C_CLR, 0, "");
    exp_img.push_back({2'd0, 24'h101010}); exp_img.push_back({2'd0, 24'h800000});
    exp_fin.push_back('{vc: 0, pc: 2, ur: 16'h0003, ua: 16'h0000});
    go(2, 1, 1);
    wait_fin("tol1");
    p(C_NVEC, 0, "tol1_vectors");
    load_tol();
    p(C_CLR, 0, "");
    exp_vec.push_back({2'd0, 14'd0, 14'd1});
    exp_img.push_back({2'd0, 24'h101010}); exp_img.push_back({2'd0, 24'h800000});
    exp_fin.push_back('{vc: 1, pc: 2, ur: 16'h0003, ua: 16'h0002});
    go(2, 2, 1);
    wait_fin("tol2");
    p(C_NVEC, 1, "tol2_vectors");
    // reset while stalled in the drain write
    load_xyz();
    cont_img = 2'd1;
    p(C_CLR, 0, "");
    exp_vec.push_back({2'd1, 14'd0, 14'd1});
    img_wait_fifo = 1;
    go(3, 0, 1);
    wait_state(4'd10, "abort_enter");
    tick(1);
    rst = 1;
    tick(1);
    rst = 0;
    img_wait_fifo = 0;
    p(C_IDLE, 1, "abort_idle"); p(C_IR, 0, "abort_img_req"); p(C_ST, 0, "abort_state");
    tick(6);
    p(C_NFIN, 0, "abort_no_finish"); p(C_NIMG, 0, "abort_no_pixels"); p(C_NVEC, 1, "abort_vectors");
    load_xyz();
    cont_img = 2'd2;
    p(C_CLR, 0, "");
    exp_vec.push_back({2'd2, 14'd0, 14'd1});
    exp_img.push_back({2'd2, PX}); exp_img.push_back({2'd2, PY}); exp_img.push_back({2'd2, PZ});
    exp_fin.push_back('{vc: 1, pc: 3, ur: 16'h0007, ua: 16'h0002});
    go(3, 0, 1);
    wait_fin("after_abort");
    p(C_NFIN, 1, "after_abort_finish");
    // empty window: straight to finish, nothing written
    p(C_CLR, 0, "");
    exp_fin.push_back('{vc: 0, pc: 0, ur: 16'h0007, ua: 16'h0002});
    go(0, 0, 0);
    p(C_FIN, 1, "empty_finish_cycle2"); p(C_ST, 11, "empty_state");
    tick(1);
    p(C_IDLE, 1, "empty_idle"); p(C_FIN, 0, "empty_finish_once");
    tick(3);
    p(C_NWE, 0, "empty_ram_writes"); p(C_NVEC, 0, "empty_vectors");
    p(C_NIMG, 0, "empty_pixels"); p(C_NFIN, 1, "empty_finish_pulses");
    p(C_QV, 0, "vectors_outstanding"); p(C_QI, 0, "pixels_outstanding"); p(C_QF, 0, "finishes_outstanding");
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
